// File: rtl/dma_prog_sequencer_pkg.sv
// Register map, bit positions and sequencer state encodings for the DMA
// register-bus initiator.
package dma_reg_pkg;

   localparam logic [31:0] OFF_INTR       = 32'h00;
   localparam logic [31:0] OFF_CTRL       = 32'h04;
   localparam logic [31:0] OFF_IO_ADDR    = 32'h08;
   localparam logic [31:0] OFF_MEM_ADDR   = 32'h0C;
   localparam logic [31:0] OFF_STATUS     = 32'h14;
   localparam logic [31:0] OFF_XFER_CNT   = 32'h18;
   localparam logic [31:0] OFF_ERR_STATUS = 32'h20;
   localparam logic [31:0] OFF_CONFIG     = 32'h24;

   localparam int unsigned STATUS_BUSY_BIT = 0;
   localparam int unsigned STATUS_DONE_BIT = 1;
   localparam int unsigned ERR_BUS_LSB     = 0;
   localparam int unsigned ERR_BUS_MSB     = 4;
   localparam int unsigned ERR_CODE_LSB    = 8;
   localparam int unsigned ERR_CODE_MSB    = 15;
   localparam logic [31:0] ERR_CLR_ALL     = 32'h0000_001F;

   typedef logic [3:0] seq_state_e;

   localparam seq_state_e S_IDLE   = 4'd0;
   localparam seq_state_e S_W_CFG  = 4'd1;
   localparam seq_state_e S_W_IO   = 4'd2;
   localparam seq_state_e S_W_MEM  = 4'd3;
   localparam seq_state_e S_W_ECLR = 4'd4;
   localparam seq_state_e S_W_CTRL = 4'd5;
   localparam seq_state_e S_GAP    = 4'd6;
   localparam seq_state_e S_P_RD   = 4'd7;
   localparam seq_state_e S_P_CHK  = 4'd8;
   localparam seq_state_e S_C_RD   = 4'd9;
   localparam seq_state_e S_C_CHK  = 4'd10;
   localparam seq_state_e S_E_RD   = 4'd11;
   localparam seq_state_e S_E_CHK  = 4'd12;
   localparam seq_state_e S_RESP   = 4'd13;

   function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] off);
      return base + off;
   endfunction

endpackage

// File: rtl/dma_prog_sequencer_poll_timer.sv
// Inter-poll gap down-counter and per-job STATUS read counter.
module dma_poll_timer #(
   parameter int unsigned POLL_GAP = 4,
   parameter int unsigned POLL_MAX = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic gap_run_i,
   input  logic poll_clr_i,
   input  logic poll_inc_i,
   output logic gap_done_o,
   output logic expired_o
);

   localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int unsigned CNT_W = $clog2(POLL_MAX + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_MAX);

   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;

   // Preloaded whenever outside GAP so GAP lasts exactly POLL_GAP cycles.
   always_comb begin
      gap_cnt_d = gap_cnt_q;
      if (!gap_run_i) begin
         gap_cnt_d = GAP_LOAD;
      end else if (gap_cnt_q != '0) begin
         gap_cnt_d = gap_cnt_q - 1'b1;
      end
   end

   always_comb begin
      poll_cnt_d = poll_cnt_q;
      if (poll_clr_i) begin
         poll_cnt_d = '0;
      end else if (poll_inc_i && (poll_cnt_q != CNT_MAX)) begin
         poll_cnt_d = poll_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt_q  <= '0;
         poll_cnt_q <= '0;
      end else begin
         gap_cnt_q  <= gap_cnt_d;
         poll_cnt_q <= poll_cnt_d;
      end
   end

   assign gap_done_o = (gap_cnt_q == '0);
   assign expired_o  = (poll_cnt_q == CNT_MAX);

endmodule

// File: rtl/dma_prog_sequencer.sv
// Register-bus initiator: programs one DMA job, polls STATUS until done or
// timeout, then returns TRANSFER_COUNT and ERROR_STATUS on a result handshake.
module dma_prog_sequencer
   import dma_reg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h400,
   parameter int unsigned POLL_GAP  = 4,
   parameter int unsigned POLL_MAX  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_io_addr,
   input  logic [31:0] job_mem_addr,
   input  logic [14:0] job_w_count,
   input  logic        job_io_mem,
   input  logic [8:0]  job_config,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_count,
   output logic [4:0]  res_err,
   output logic [7:0]  res_err_code,
   output logic        res_timeout,
   output logic        wr_en,
   output logic        rd_en,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata
);

   seq_state_e  state_q, state_d;
   logic [31:0] io_addr_q, io_addr_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [14:0] w_count_q, w_count_d;
   logic        io_mem_q, io_mem_d;
   logic [8:0]  cfg_q, cfg_d;
   logic        wr_en_q, wr_en_d;
   logic        rd_en_q, rd_en_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] res_count_q, res_count_d;
   logic [4:0]  res_err_q, res_err_d;
   logic [7:0]  res_code_q, res_code_d;
   logic        res_timeout_q, res_timeout_d;

   logic job_accept;
   logic gap_done;
   logic poll_expired;
   logic status_done;

   assign job_accept  = job_valid && (state_q == S_IDLE);
   assign status_done = !rdata[STATUS_BUSY_BIT] && rdata[STATUS_DONE_BIT];

   dma_poll_timer #(
      .POLL_GAP (POLL_GAP),
      .POLL_MAX (POLL_MAX)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .gap_run_i  (state_q == S_GAP),
      .poll_clr_i (job_accept),
      .poll_inc_i (state_q == S_P_RD),
      .gap_done_o (gap_done),
      .expired_o  (poll_expired)
   );

   always_comb begin
      state_d       = state_q;
      io_addr_d     = io_addr_q;
      mem_addr_d    = mem_addr_q;
      w_count_d     = w_count_q;
      io_mem_d      = io_mem_q;
      cfg_d         = cfg_q;
      res_count_d   = res_count_q;
      res_err_d     = res_err_q;
      res_code_d    = res_code_q;
      res_timeout_d = res_timeout_q;
      wr_en_d       = 1'b0;
      rd_en_d       = 1'b0;
      addr_d        = '0;
      wdata_d       = '0;

      case (state_q)
         S_IDLE: begin
            if (job_accept) begin
               io_addr_d     = job_io_addr;
               mem_addr_d    = job_mem_addr;
               w_count_d     = job_w_count;
               io_mem_d      = job_io_mem;
               cfg_d         = job_config;
               res_timeout_d = 1'b0;
               state_d       = S_W_CFG;
            end
         end
         S_W_CFG:  state_d = S_W_IO;
         S_W_IO:   state_d = S_W_MEM;
         S_W_MEM:  state_d = S_W_ECLR;
         S_W_ECLR: state_d = S_W_CTRL;
         S_W_CTRL: state_d = S_GAP;
         S_GAP: begin
            if (gap_done) begin
               state_d = S_P_RD;
            end
         end
         S_P_RD:   state_d = S_P_CHK;
         S_P_CHK: begin
            if (status_done) begin
               state_d = S_C_RD;
            end else if (poll_expired) begin
               res_timeout_d = 1'b1;
               state_d       = S_C_RD;
            end else begin
               state_d = S_GAP;
            end
         end
         S_C_RD:   state_d = S_C_CHK;
         S_C_CHK: begin
            res_count_d = rdata;
            state_d     = S_E_RD;
         end
         S_E_RD:   state_d = S_E_CHK;
         S_E_CHK: begin
            res_err_d  = rdata[ERR_BUS_MSB:ERR_BUS_LSB];
            res_code_d = rdata[ERR_CODE_MSB:ERR_CODE_LSB];
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default:  state_d = S_IDLE;
      endcase

      // Bus strobes are decoded from the next state so they register together with it.
      case (state_d)
         S_W_CFG: begin
            wr_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_CONFIG);
            wdata_d = {23'b0, cfg_d};
         end
         S_W_IO: begin
            wr_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_IO_ADDR);
            wdata_d = io_addr_d;
         end
         S_W_MEM: begin
            wr_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_MEM_ADDR);
            wdata_d = mem_addr_d;
         end
         S_W_ECLR: begin
            wr_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_ERR_STATUS);
            wdata_d = ERR_CLR_ALL;
         end
         S_W_CTRL: begin
            wr_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_CTRL);
            wdata_d = {15'b0, io_mem_d, w_count_d, 1'b1};
         end
         S_P_RD: begin
            rd_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_STATUS);
         end
         S_C_RD: begin
            rd_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_XFER_CNT);
         end
         S_E_RD: begin
            rd_en_d = 1'b1;
            addr_d  = reg_addr(BASE_ADDR, OFF_ERR_STATUS);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         io_addr_q     <= '0;
         mem_addr_q    <= '0;
         w_count_q     <= '0;
         io_mem_q      <= 1'b0;
         cfg_q         <= '0;
         wr_en_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         res_count_q   <= '0;
         res_err_q     <= '0;
         res_code_q    <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         io_addr_q     <= io_addr_d;
         mem_addr_q    <= mem_addr_d;
         w_count_q     <= w_count_d;
         io_mem_q      <= io_mem_d;
         cfg_q         <= cfg_d;
         wr_en_q       <= wr_en_d;
         rd_en_q       <= rd_en_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         res_count_q   <= res_count_d;
         res_err_q     <= res_err_d;
         res_code_q    <= res_code_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   assign job_ready    = (state_q == S_IDLE);
   assign res_valid    = (state_q == S_RESP);
   assign res_count    = res_count_q;
   assign res_err      = res_err_q;
   assign res_err_code = res_code_q;
   assign res_timeout  = res_timeout_q;
   assign wr_en        = wr_en_q;
   assign rd_en        = rd_en_q;
   assign addr         = addr_q;
   assign wdata        = wdata_q;

endmodule

// File: tb/tb_dma_prog_sequencer.sv
// Scoreboard bench for dma_prog_sequencer with a behavioural DMA register file.
module tb_dma_prog_sequencer;

   localparam int unsigned GAP  = 4;
   localparam int unsigned PMAX = 8;

   localparam logic [31:0] A_CTRL = 32'h404;
   localparam logic [31:0] A_IO   = 32'h408;
   localparam logic [31:0] A_MEM  = 32'h40C;
   localparam logic [31:0] A_STAT = 32'h414;
   localparam logic [31:0] A_CNT  = 32'h418;
   localparam logic [31:0] A_ERR  = 32'h420;
   localparam logic [31:0] A_CFG  = 32'h424;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [31:0] job_io_addr = '0;
   logic [31:0] job_mem_addr = '0;
   logic [14:0] job_w_count = '0;
   logic        job_io_mem = 1'b0;
   logic [8:0]  job_config = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_count;
   logic [4:0]  res_err;
   logic [7:0]  res_err_code;
   logic        res_timeout;
   logic        wr_en, rd_en;
   logic [31:0] addr, wdata;
   logic [31:0] rdata = '0;

   always #5 clk = ~clk;

   dma_prog_sequencer #(
      .BASE_ADDR (32'h400),
      .POLL_GAP  (GAP),
      .POLL_MAX  (PMAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_io_addr  (job_io_addr),
      .job_mem_addr (job_mem_addr),
      .job_w_count  (job_w_count),
      .job_io_mem   (job_io_mem),
      .job_config   (job_config),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_count    (res_count),
      .res_err      (res_err),
      .res_err_code (res_err_code),
      .res_timeout  (res_timeout),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata)
   );

   typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
   typedef struct packed { logic [31:0] cnt; logic [4:0] err; logic [7:0] code; logic to; } res_t;
   typedef struct packed { int unsigned done_after; logic busy_forever; logic inject; } mcfg_t;
   typedef struct {
      logic [31:0] io; logic [31:0] mem; logic [14:0] wc; logic iom; logic [8:0] cfg;
      logic [31:0] ctrl_exp; int unsigned done_after; logic busy_forever; logic inject;
      int unsigned polls_exp; logic [31:0] cnt_exp; logic [4:0] err_exp; logic [7:0] code_exp; logic to_exp;
   } job_t;

   wr_t         exp_wr_q[$];
   res_t        exp_res_q[$];
   int unsigned exp_poll_q[$];
   mcfg_t       mcfg_q[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register file model: STATUS reads stale done for a few cycles after start.
   mcfg_t       m_cur = '0;
   int unsigned m_since = 1000;
   int unsigned m_reads = 0;
   logic [4:0]  m_err = '0;
   logic [7:0]  m_code = '0;
   logic [31:0] m_count = '0;

   always @(posedge clk) begin
      if (rst) begin
         mcfg_q.delete();
         m_since = 1000;
         m_reads = 0;
         m_err   = '0;
         m_code  = '0;
      end else begin
         if (rd_en) begin
            case (addr)
               A_STAT: begin
                  if (m_since < 3) begin
                     rdata <= 32'h2;
                  end else begin
                     m_reads++;
                     if (!m_cur.busy_forever && m_reads >= m_cur.done_after) rdata <= 32'h2;
                     else rdata <= 32'h1;
                  end
               end
               A_CNT:   rdata <= m_count;
               A_ERR:   rdata <= {16'h0, m_code, 3'b0, m_err};
               default: rdata <= '0;
            endcase
         end
         if (wr_en && addr == A_CTRL && wdata[0]) begin
            if (mcfg_q.size() > 0) m_cur = mcfg_q.pop_front();
            m_since = 0;
            m_reads = 0;
            m_count = {17'b0, wdata[15:1]} + 32'd1;
            if (m_cur.inject) begin
               m_err  = 5'h01;
               m_code = 8'h5A;
            end
         end else if (m_since < 1000) begin
            m_since++;
         end
         if (wr_en && addr == A_ERR) begin
            m_err = m_err & ~wdata[4:0];
            if (m_err == '0) m_code = '0;
         end
      end
   end

   // Monitor / scoreboard
   int unsigned cyc = 0;
   int unsigned last_acc = 0;
   int unsigned poll_reads = 0;
   int          outstanding = 0;
   logic        prev_wr = 1'b0, prev_rd = 1'b0, expect_err_rd = 1'b0, hold = 1'b0;
   logic [31:0] prev_addr = '0;
   res_t        prev_res = '0;
   wr_t         w;
   res_t        r;
   int unsigned ep;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_wr_q.delete();
         exp_res_q.delete();
         exp_poll_q.delete();
         outstanding   = 0;
         poll_reads    = 0;
         expect_err_rd = 1'b0;
         prev_wr       = 1'b0;
         prev_rd       = 1'b0;
         hold          = 1'b0;
      end else begin
         check("bus_exclusive", {63'b0, wr_en && rd_en}, 64'd0);
         if (wr_en) begin
            if (prev_wr) check("wr_one_per_access", {63'b0, addr != prev_addr}, 64'd1);
            if (exp_wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", addr, wdata);
            end else begin
               w = exp_wr_q.pop_front();
               check("wr_addr", {32'b0, addr}, {32'b0, w.a});
               check("wr_data", {32'b0, wdata}, {32'b0, w.d});
            end
            last_acc = cyc;
         end
         if (rd_en) begin
            check("rd_strobe_width", {63'b0, prev_rd}, 64'd0);
            if (outstanding == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: got addr 0x%0h expected none", addr);
            end
            if (addr == A_STAT) begin
               check("poll_gap_ok", {63'b0, (cyc - last_acc) >= GAP + 1}, 64'd1);
               poll_reads++;
            end else if (addr == A_CNT) begin
               if (exp_poll_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL poll_count: got %0d reads expected no count readback", poll_reads);
               end else begin
                  ep = exp_poll_q.pop_front();
                  check("poll_count", 64'(poll_reads), 64'(ep));
               end
               poll_reads    = 0;
               expect_err_rd = 1'b1;
            end else if (addr == A_ERR) begin
               check("err_read_after_count", {63'b0, expect_err_rd}, 64'd1);
               expect_err_rd = 1'b0;
            end else begin
               check("rd_addr_legal", {32'b0, addr}, {32'b0, A_STAT});
            end
            last_acc = cyc;
         end
         prev_wr   = wr_en;
         prev_rd   = rd_en;
         prev_addr = addr;

         check("job_ready_only_when_idle", {63'b0, job_ready}, {63'b0, outstanding == 0});
         if (job_valid && job_ready) outstanding++;

         if (res_valid && hold)
            check("res_stable", {18'b0, res_count, res_err, res_err_code, res_timeout}, {18'b0, prev_res});
         if (res_valid && res_ready) begin
            if (exp_res_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result: got count 0x%0h expected none", res_count);
            end else begin
               r = exp_res_q.pop_front();
               check("res_count", {32'b0, res_count}, {32'b0, r.cnt});
               check("res_err", {59'b0, res_err}, {59'b0, r.err});
               check("res_err_code", {56'b0, res_err_code}, {56'b0, r.code});
               check("res_timeout", {63'b0, res_timeout}, {63'b0, r.to});
            end
            outstanding--;
         end
         hold     = res_valid && !res_ready;
         prev_res = {res_count, res_err, res_err_code, res_timeout};
      end
   end

   task automatic send_job(input job_t j);
      int n;
      exp_wr_q.push_back({A_CFG, {23'b0, j.cfg}});
      exp_wr_q.push_back({A_IO, j.io});
      exp_wr_q.push_back({A_MEM, j.mem});
      exp_wr_q.push_back({A_ERR, 32'h1F});
      exp_wr_q.push_back({A_CTRL, j.ctrl_exp});
      exp_poll_q.push_back(j.polls_exp);
      exp_res_q.push_back({j.cnt_exp, j.err_exp, j.code_exp, j.to_exp});
      mcfg_q.push_back({j.done_after, j.busy_forever, j.inject});
      job_io_addr  = j.io;
      job_mem_addr = j.mem;
      job_w_count  = j.wc;
      job_io_mem   = j.iom;
      job_config   = j.cfg;
      job_valid    = 1'b1;
      n = 0;
      while (!job_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("job_accept_in_time", {63'b0, job_ready}, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((outstanding != 0 || exp_res_q.size() != 0 || exp_wr_q.size() != 0) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_in_time", {63'b0, outstanding == 0 && exp_res_q.size() == 0 && exp_wr_q.size() == 0}, 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   job_t jobs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      jobs[0] = '{32'h1000, 32'h2000, 15'd3, 1'b1, 9'h0A9, 32'h10007, 2, 1'b0, 1'b0, 2, 32'd4, 5'h00, 8'h00, 1'b0};
      jobs[1] = '{32'h3000, 32'h4000, 15'd10, 1'b0, 9'h1FF, 32'h00015, 0, 1'b1, 1'b0, 8, 32'd11, 5'h00, 8'h00, 1'b1};
      jobs[2] = '{32'h5000, 32'h6000, 15'h7FFF, 1'b1, 9'h000, 32'h1FFFF, 1, 1'b0, 1'b1, 1, 32'h8000, 5'h01, 8'h5A, 1'b0};
      jobs[3] = '{32'h7000, 32'h8000, 15'd0, 1'b0, 9'h055, 32'h00001, 3, 1'b0, 1'b0, 3, 32'd1, 5'h00, 8'h00, 1'b0};
      jobs[4] = '{32'hA0A0_0000, 32'hB0B0_0000, 15'd5, 1'b1, 9'h100, 32'h1000B, 2, 1'b0, 1'b0, 2, 32'd6, 5'h00, 8'h00, 1'b0};
      jobs[5] = '{32'hC000, 32'hD000, 15'd7, 1'b0, 9'h011, 32'h0000F, 4, 1'b0, 1'b0, 4, 32'd8, 5'h00, 8'h00, 1'b0};
      jobs[6] = '{32'hE000, 32'hF000, 15'd1, 1'b1, 9'h1A5, 32'h10003, 2, 1'b0, 1'b0, 2, 32'd2, 5'h00, 8'h00, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", {63'b0, wr_en}, 64'd0);
      check("rst_rd_en", {63'b0, rd_en}, 64'd0);
      check("rst_addr", {32'b0, addr}, 64'd0);
      check("rst_wdata", {32'b0, wdata}, 64'd0);
      check("rst_job_ready", {63'b0, job_ready}, 64'd1);
      check("rst_res_valid", {63'b0, res_valid}, 64'd0);
      check("rst_res", {18'b0, res_count, res_err, res_err_code, res_timeout}, 64'd0);
      rst = 1'b0;

      send_job(jobs[0]); job_valid = 1'b0; wait_idle();
      send_job(jobs[1]); job_valid = 1'b0; wait_idle();
      send_job(jobs[2]); send_job(jobs[3]); job_valid = 1'b0; wait_idle();

      res_ready = 1'b0;
      send_job(jobs[4]); job_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("res_valid_in_time", {63'b0, res_valid}, 64'd1);
      repeat (10) @(posedge clk);
      #1;
      res_ready = 1'b1;
      wait_idle();

      send_job(jobs[5]); job_valid = 1'b0;
      n = 0;
      while (!(rd_en && addr == A_STAT) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("poll_seen_before_abort", {63'b0, rd_en && addr == A_STAT}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_wr_en", {63'b0, wr_en}, 64'd0);
      check("abort_rd_en", {63'b0, rd_en}, 64'd0);
      check("abort_job_ready", {63'b0, job_ready}, 64'd1);
      check("abort_res_valid", {63'b0, res_valid}, 64'd0);
      check("abort_addr", {32'b0, addr}, 64'd0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      send_job(jobs[6]); job_valid = 1'b0; wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
